cache_mem_arbiter: RTL and testbench

- Sits between the instruction cache, the data cache (d_cache) and the SDRAM controller.
- Arbitrates the two caches' 64-bit block requests.
- Serialises each block into a 4-beat 16-bit burst on the controller side, and reassembles read bursts into a 64-bit block.
- Returns the block with a single-cycle ready pulse, matching the caches' req/ready handshake.

---
 rtl/cache_mem_arbiter_pkg.sv | 11 +
 rtl/cache_mem_arbiter_block_serdes.sv | 31 +++
 rtl/cache_mem_arbiter.sv | 92 +++++++++
 tb/tb_cache_mem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: shared state encoding, beat sizing and grant constants
package cache_mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, CMD, XFER, DONE} state_t;
  localparam int BEATS = 4;
  localparam int BEAT_W = $clog2(BEATS);
  typedef logic [BEAT_W:0] beat_t;
  localparam beat_t BEAT_LAST = beat_t'(BEATS - 1);
  localparam beat_t BEAT_END = beat_t'(BEATS);
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
endpackage

// File: rtl/cache_mem_arbiter_block_serdes.sv
// cache_mem_arbiter_block_serdes: 64-bit block to/from 16-bit beat serialiser
module cache_mem_arbiter_block_serdes import cache_mem_arbiter_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] wblock,
  input  logic        take,
  input  logic        rvalid,
  input  logic [15:0] rdata,
  output logic [15:0] wdata,
  output logic [63:0] rbuf,
  output beat_t       beat
);
  logic [63:0] wbuf;
  always_ff @(posedge clk) begin
    if (rst) begin
      wbuf <= '0;
      rbuf <= '0;
      beat <= '0;
    end else if (load) begin
      wbuf <= wblock;
      beat <= '0;
    end else if (take && beat < BEAT_LAST) begin
      beat <= beat + 1'b1;
    end else if (rvalid && beat < BEAT_END) begin
      rbuf[{beat[BEAT_W-1:0], 4'b0} +: 16] <= rdata;
      beat <= beat + 1'b1;
    end
  end
  assign wdata = wbuf[{beat[BEAT_W-1:0], 4'b0} +: 16];
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin i/d cache arbiter feeding 4-beat SDRAM bursts
module cache_mem_arbiter #(
  parameter int BLOCK_AW = 13,
  parameter int BEATS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [BLOCK_AW-1:0] i_address,
  output logic [63:0]         i_from_mem,
  output logic                i_ready,
  input  logic                d_req,
  input  logic                d_wren,
  input  logic [BLOCK_AW-1:0] d_address,
  input  logic [63:0]         d_to_mem,
  output logic [63:0]         d_from_mem,
  output logic                d_ready,
  output logic                ctrl_req,
  output logic                ctrl_wren,
  output logic [BLOCK_AW+1:0] ctrl_address,
  input  logic                ctrl_ack,
  output logic [15:0]         ctrl_wdata,
  input  logic                ctrl_wdata_take,
  input  logic [15:0]         ctrl_rdata,
  input  logic                ctrl_rdata_valid,
  input  logic                ctrl_done,
  output logic                busy,
  output logic                grant_d
);
  import cache_mem_arbiter_pkg::*;
  state_t state, state_n;
  logic grant, wren, done_pend, accept, pick_d;
  logic [BLOCK_AW-1:0] addr;
  logic [63:0] rbuf;
  beat_t beat;
  assign accept = state == IDLE && (i_req || d_req);
  // grant register doubles as last_grant: both requesting picks the other port
  assign pick_d = d_req && (!i_req || grant == GRANT_I);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= GRANT_I;
      wren <= 1'b0;
      addr <= '0;
      done_pend <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        grant <= pick_d;
        wren <= pick_d & d_wren;
        addr <= pick_d ? d_address : i_address;
        done_pend <= 1'b0;
      end else if (state == CMD && ctrl_ack && ctrl_done) begin
        done_pend <= 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = (i_req || d_req) ? CMD : IDLE;
      CMD: state_n = ctrl_ack ? XFER : CMD;
      XFER: state_n = (ctrl_done || done_pend) ? DONE : XFER;
      default: state_n = IDLE;
    endcase
  end
  cache_mem_arbiter_block_serdes u_serdes (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .wblock(d_to_mem),
    .take(state == XFER && wren && ctrl_wdata_take),
    .rvalid(state == XFER && !wren && ctrl_rdata_valid),
    .rdata(ctrl_rdata),
    .wdata(ctrl_wdata),
    .rbuf(rbuf),
    .beat(beat)
  );
  assign ctrl_req = state == CMD;
  assign ctrl_wren = wren;
  assign ctrl_address = {addr, 2'b00};
  assign busy = state != IDLE;
  assign grant_d = grant;
  assign i_ready = state == DONE && grant == GRANT_I;
  assign d_ready = state == DONE && grant == GRANT_D;
  assign i_from_mem = rbuf;
  assign d_from_mem = rbuf;
  // a read burst must deliver every beat before the controller signals done
  assert property (@(posedge clk) disable iff (rst)
    (state == XFER && !wren && ctrl_done) |->
      (beat == beat_t'(BEATS) || (ctrl_rdata_valid && beat == beat_t'(BEATS - 1))));
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: randomized scenario bench with a transaction-level reference model
module tb_cache_mem_arbiter;
  logic clk = 0, rst = 1;
  logic i_req = 0, i_ready, d_req = 0, d_wren = 0, d_ready;
  logic [12:0] i_address = 0, d_address = 0;
  logic [63:0] i_from_mem, d_from_mem, d_to_mem = 0;
  logic ctrl_req, ctrl_wren, ctrl_ack = 0, ctrl_wdata_take = 0, ctrl_rdata_valid = 0, ctrl_done = 0;
  logic [14:0] ctrl_address;
  logic [15:0] ctrl_wdata, ctrl_rdata = 0;
  logic busy, grant_d;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_address(i_address), .i_from_mem(i_from_mem), .i_ready(i_ready),
    .d_req(d_req), .d_wren(d_wren), .d_address(d_address), .d_to_mem(d_to_mem),
    .d_from_mem(d_from_mem), .d_ready(d_ready),
    .ctrl_req(ctrl_req), .ctrl_wren(ctrl_wren), .ctrl_address(ctrl_address), .ctrl_ack(ctrl_ack),
    .ctrl_wdata(ctrl_wdata), .ctrl_wdata_take(ctrl_wdata_take), .ctrl_rdata(ctrl_rdata),
    .ctrl_rdata_valid(ctrl_rdata_valid), .ctrl_done(ctrl_done), .busy(busy), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, done_at = 0;
  int o_ip, o_dp, o_lat;
  logic o_wren, o_reqlow, keep_d = 0;
  logic [14:0] o_addr;
  logic [63:0] o_wdata;
  logic m_last = 0;
  logic [63:0] m_rbuf = 0;

  // one cycle: observe ready pulses like a cache would, then clear controller strobes
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (i_ready) begin
      o_ip++;
      i_req = 0;
      if (o_lat < 0) o_lat = cyc - done_at;
    end
    if (d_ready) begin
      o_dp++;
      if (o_lat < 0) o_lat = cyc - done_at;
      if (keep_d) begin
        d_wren = 0;
        keep_d = 0;
      end else d_req = 0;
    end
    ctrl_ack = 0; ctrl_done = 0; ctrl_rdata_valid = 0; ctrl_wdata_take = 0;
  endtask

  // behaves as the SDRAM controller for one burst and records what the DUT presented
  task automatic serve(input int ack_dly, input int nvalid, input bit coinc, input int post,
                       input logic [63:0] rd);
    int t;
    o_ip = 0; o_dp = 0; o_lat = -1; o_wdata = 0; t = 0;
    do begin
      tick();
      t++;
    end while (!ctrl_req && t < 20);
    checks++;
    if (!ctrl_req) begin
      errors++;
      $display("FAIL ctrl_req_timeout got 0 exp 1");
      return;
    end
    o_addr = ctrl_address;
    o_wren = ctrl_wren;
    repeat (ack_dly) tick();
    ctrl_ack = 1;
    tick();
    o_reqlow = ctrl_req;
    if (o_wren) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(1) == 1) tick();
        o_wdata[16*k +: 16] = ctrl_wdata;
        ctrl_wdata_take = 1;
        tick();
      end
      ctrl_done = 1;
      done_at = cyc;
      tick();
    end else begin
      for (int k = 0; k < nvalid; k++) begin
        ctrl_rdata = (k < 4) ? rd[16*k +: 16] : 16'hBAD1;
        ctrl_rdata_valid = 1;
        if (coinc && k == nvalid - 1) begin
          ctrl_done = 1;
          done_at = cyc;
        end
        tick();
      end
      if (!coinc) begin
        ctrl_done = 1;
        done_at = cyc;
        tick();
      end
      repeat (post) begin
        ctrl_rdata = 16'hBAD0;
        ctrl_rdata_valid = 1;
        tick();
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) tick();
    checks++;
    if ({busy, ctrl_req, i_ready, d_ready, ctrl_wren, grant_d} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000000", {busy, ctrl_req, i_ready, d_ready, ctrl_wren, grant_d});
    end
    checks++;
    if ({ctrl_address, ctrl_wdata} !== 31'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %h exp 0", {ctrl_address, ctrl_wdata});
    end
    checks++;
    if ({i_from_mem, d_from_mem} !== 128'b0) begin
      errors++;
      $display("FAIL reset_rbuf got %h exp 0", {i_from_mem, d_from_mem});
    end
    rst = 0;
    m_last = 0;
    m_rbuf = 0;
  endtask

  task automatic test_d_read();
    d_req = 1; d_wren = 0; d_address = 13'h0A5;
    serve(2, 4, 0, 0, 64'h4444_3333_2222_1111);
    m_rbuf = 64'h4444_3333_2222_1111;
    m_last = 1;
    checks++;
    if (o_addr !== 15'h0294) begin errors++; $display("FAIL d_read_addr got %h exp 0294", o_addr); end
    checks++;
    if (o_wren !== 1'b0) begin errors++; $display("FAIL d_read_wren got %b exp 0", o_wren); end
    checks++;
    if (o_reqlow !== 1'b0) begin errors++; $display("FAIL d_read_req_after_ack got %b exp 0", o_reqlow); end
    checks++;
    if (o_dp !== 1 || o_ip !== 0) begin errors++; $display("FAIL d_read_pulses got d%0d i%0d exp d1 i0", o_dp, o_ip); end
    checks++;
    if (o_lat !== 1) begin errors++; $display("FAIL d_read_latency got %0d exp 1", o_lat); end
    checks++;
    if (d_from_mem !== m_rbuf || i_from_mem !== m_rbuf) begin
      errors++;
      $display("FAIL d_read_data got %h/%h exp %h", d_from_mem, i_from_mem, m_rbuf);
    end
    checks++;
    if (grant_d !== 1'b1) begin errors++; $display("FAIL d_read_grant got %b exp 1", grant_d); end
  endtask

  task automatic test_d_write();
    d_req = 1; d_wren = 1; d_address = 13'h1234; d_to_mem = 64'hDEAD_BEEF_0123_4567;
    serve(1, 4, 0, 0, 64'h0);
    m_last = 1;
    checks++;
    if (o_wren !== 1'b1) begin errors++; $display("FAIL d_write_wren got %b exp 1", o_wren); end
    checks++;
    if (o_addr !== 15'h48D0) begin errors++; $display("FAIL d_write_addr got %h exp 48d0", o_addr); end
    checks++;
    if (o_wdata !== 64'hDEAD_BEEF_0123_4567) begin
      errors++;
      $display("FAIL d_write_beats got %h exp deadbeef01234567", o_wdata);
    end
    checks++;
    if (o_dp !== 1 || o_ip !== 0 || o_lat !== 1) begin
      errors++;
      $display("FAIL d_write_ready got d%0d i%0d lat%0d exp d1 i0 lat1", o_dp, o_ip, o_lat);
    end
    checks++;
    if (d_from_mem !== m_rbuf) begin errors++; $display("FAIL d_write_rbuf got %h exp %h", d_from_mem, m_rbuf); end
  endtask

  task automatic test_contention();
    logic [63:0] rd;
    test_reset();
    d_wren = 0;
    for (int r = 0; r < 4; r++) begin
      if (r % 2 == 0) begin
        i_address = 13'h0100 + 13'(r); d_address = 13'h0200 + 13'(r);
        i_req = 1; d_req = 1;
      end
      rd = {$urandom, $urandom};
      serve($urandom_range(2), 4, 0, 0, rd);
      m_rbuf = rd;
      checks++;
      if (o_dp !== (r % 2 == 0 ? 1 : 0) || o_ip !== (r % 2 == 0 ? 0 : 1)) begin
        errors++;
        $display("FAIL contention_order_%0d got d%0d i%0d", r, o_dp, o_ip);
      end
      checks++;
      if (o_addr !== {(r % 2 == 0) ? d_address : i_address, 2'b00}) begin
        errors++;
        $display("FAIL contention_addr_%0d got %h", r, o_addr);
      end
      checks++;
      if (i_from_mem !== m_rbuf) begin errors++; $display("FAIL contention_data_%0d got %h exp %h", r, i_from_mem, m_rbuf); end
    end
    m_last = 0;
  endtask

  task automatic test_wb_then_fetch();
    logic [63:0] rd;
    int total;
    i_req = 0;
    d_req = 1; d_wren = 1; d_address = 13'h0777; d_to_mem = 64'h0F0F_1E1E_2D2D_3C3C;
    keep_d = 1;
    serve(0, 4, 0, 0, 64'h0);
    total = o_dp;
    checks++;
    if (o_wren !== 1'b1 || o_wdata !== 64'h0F0F_1E1E_2D2D_3C3C) begin
      errors++;
      $display("FAIL wbf_write got wren %b data %h", o_wren, o_wdata);
    end
    rd = {$urandom, $urandom};
    serve(1, 4, 1, 0, rd);
    total += o_dp;
    m_rbuf = rd;
    m_last = 1;
    checks++;
    if (o_wren !== 1'b0 || o_addr !== 15'h1DDC) begin
      errors++;
      $display("FAIL wbf_fetch got wren %b addr %h exp 0 1ddc", o_wren, o_addr);
    end
    checks++;
    if (total !== 2 || d_req !== 1'b0) begin errors++; $display("FAIL wbf_pulses got %0d exp 2", total); end
    checks++;
    if (d_from_mem !== m_rbuf) begin errors++; $display("FAIL wbf_data got %h exp %h", d_from_mem, m_rbuf); end
  endtask

  task automatic test_reset_mid();
    int t;
    d_req = 1; d_wren = 0; d_address = 13'h0042;
    t = 0;
    do begin
      tick();
      t++;
    end while (!ctrl_req && t < 20);
    ctrl_ack = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      ctrl_rdata = 16'hA000 + 16'(k);
      ctrl_rdata_valid = 1;
      tick();
    end
    rst = 1; d_req = 0; o_dp = 0; o_ip = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || ctrl_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state got busy %b req %b exp 0 0", busy, ctrl_req);
    end
    rst = 0;
    m_last = 0;
    m_rbuf = 0;
    repeat (3) tick();
    checks++;
    if (o_dp !== 0 || o_ip !== 0) begin errors++; $display("FAIL reset_mid_ready got d%0d i%0d exp 0", o_dp, o_ip); end
    checks++;
    if (d_from_mem !== 64'h0) begin errors++; $display("FAIL reset_mid_rbuf got %h exp 0", d_from_mem); end
    d_req = 1;
    serve(1, 4, 0, 0, 64'h8888_7777_6666_5555);
    m_rbuf = 64'h8888_7777_6666_5555;
    m_last = 1;
    checks++;
    if (d_from_mem !== m_rbuf || o_dp !== 1) begin
      errors++;
      $display("FAIL reset_mid_recover got %h d%0d exp %h d1", d_from_mem, o_dp, m_rbuf);
    end
  endtask

  task automatic test_coincident();
    d_req = 1; d_wren = 0; d_address = 13'h0003;
    serve(0, 4, 1, 1, 64'hCAFE_0004_0003_0002);
    m_rbuf = 64'hCAFE_0004_0003_0002;
    m_last = 1;
    checks++;
    if (d_from_mem !== m_rbuf) begin errors++; $display("FAIL coincident_data got %h exp %h", d_from_mem, m_rbuf); end
    checks++;
    if (o_dp !== 1 || o_lat !== 1) begin errors++; $display("FAIL coincident_ready got d%0d lat%0d exp d1 lat1", o_dp, o_lat); end
    d_req = 1;
    serve(2, 5, 0, 0, 64'h1357_9BDF_2468_ACE0);
    m_rbuf = 64'h1357_9BDF_2468_ACE0;
    checks++;
    if (d_from_mem !== m_rbuf || o_dp !== 1) begin
      errors++;
      $display("FAIL extra_beat got %h d%0d exp %h d1", d_from_mem, o_dp, m_rbuf);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      bit want_i, want_d, p;
      logic [63:0] rd;
      logic [14:0] exp_addr;
      want_i = 1'($urandom_range(1));
      want_d = 1'($urandom_range(1));
      if (!want_i && !want_d) want_d = 1;
      i_address = 13'($urandom); d_address = 13'($urandom);
      d_wren = 1'($urandom_range(1)); d_to_mem = {$urandom, $urandom};
      i_req = want_i; d_req = want_d;
      while (want_i || want_d) begin
        p = (want_i && want_d) ? !m_last : want_d;
        exp_addr = {p ? d_address : i_address, 2'b00};
        rd = {$urandom, $urandom};
        serve($urandom_range(3), 4, 1'($urandom_range(1)), 0, rd);
        checks++;
        if (o_dp !== int'(p) || o_ip !== int'(!p)) begin
          errors++;
          $display("FAIL rand_grant_%0d got d%0d i%0d exp d%0d", n, o_dp, o_ip, p);
        end
        checks++;
        if (o_addr !== exp_addr || o_wren !== (p & d_wren)) begin
          errors++;
          $display("FAIL rand_cmd_%0d got %h/%b exp %h/%b", n, o_addr, o_wren, exp_addr, p & d_wren);
        end
        if (p && d_wren) begin
          checks++;
          if (o_wdata !== d_to_mem) begin errors++; $display("FAIL rand_wdata_%0d got %h exp %h", n, o_wdata, d_to_mem); end
        end else m_rbuf = rd;
        checks++;
        if (d_from_mem !== m_rbuf || i_from_mem !== m_rbuf) begin
          errors++;
          $display("FAIL rand_rdata_%0d got %h exp %h", n, d_from_mem, m_rbuf);
        end
        m_last = p;
        if (p) want_d = 0;
        else want_i = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_d_read();
    test_d_write();
    test_contention();
    test_wb_then_fetch();
    test_reset_mid();
    test_coincident();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
